tone_sequencer: RTL

//  Bus-slave sequencer that plays a programmed list of tones on the square-wave generator.
//  CPU loads up to DEPTH (threshold, duration) entries, then writes START.

---
 rtl/tone_sequencer_pkg.sv | 34 +++
 rtl/tone_seq_table.sv | 53 +++++
 rtl/tone_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_pkg.sv
// tone_sequencer_pkg
//   Shared sequencer state type, register word offsets (addr[9:2]),
//   CTRL bit positions and the byte-strobe merge helper.
package tone_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    HOLD    = 2'd2,
    SILENCE = 2'd3
  } seq_state_t;

  // Word offsets, i.e. byte address >> 2
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;
  localparam logic [7:0] REG_LENGTH = 8'h02;
  localparam logic [7:0] REG_IRQ    = 8'h03;
  localparam logic [7:0] REG_TABLE  = 8'h40;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] nxt,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? nxt[8*b +: 8] : cur[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tone_seq_table.sv
// tone_seq_table
//   DEPTH entries of (32-bit threshold, DUR_W-bit duration).
//   Ports: clk, resetn (async active-low); one byte-strobed write port
//   (we, wsel_dur selects the duration field, widx, wstrb, wdata);
//   read port a (slave readback, duration zero-extended to 32 bits);
//   read port b (sequencer). Both read ports are combinational.
module tone_seq_table
  import tone_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DUR_W = 24,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic             wsel_dur,
  input  logic [IDX_W-1:0] widx,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] ridx_a,
  output logic [31:0]      rthresh_a,
  output logic [31:0]      rdur_a,
  input  logic [IDX_W-1:0] ridx_b,
  output logic [31:0]      rthresh_b,
  output logic [DUR_W-1:0] rdur_b
);

  logic [31:0]      thresh_q [DEPTH];
  logic [DUR_W-1:0] dur_q    [DEPTH];
  logic [31:0]      dur_merge;

  // Duration strobes act on the zero-extended 32-bit view; upper bits drop.
  assign dur_merge = apply_wstrb(32'(dur_q[widx]), wdata, wstrb);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        thresh_q[i] <= '0;
        dur_q[i]    <= '0;
      end
    end else if (we) begin
      if (wsel_dur) dur_q[widx] <= dur_merge[DUR_W-1:0];
      else          thresh_q[widx] <= apply_wstrb(thresh_q[widx], wdata, wstrb);
    end
  end

  assign rthresh_a = thresh_q[ridx_a];
  assign rdur_a    = 32'(dur_q[ridx_a]);
  assign rthresh_b = thresh_q[ridx_b];
  assign rdur_b    = dur_q[ridx_b];

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Bus slave holding a tone table; once started it masters the square-wave
//   generator CSR port, writing each threshold and holding it for its
//   duration, then writes 0 to silence the generator.
//   Slave port : valid, ready, wstrb (0 = read), addr, wdata, rdata
//   Master port: m_valid, m_ready, m_wstrb, m_addr, m_wdata
//   Status     : busy; irq when TONE_SEQUENCER_IRQ_EN is defined
//   Optional   : TONE_SEQUENCER_IRQ_EN adds the done-sticky IRQ register and irq port.
//
//   state   | meaning
//   IDLE    | waiting for START with non-empty table
//   WRITE   | m_valid high with THRESH[idx], waiting for m_ready
//   HOLD    | dcnt counting down the tone duration
//   SILENCE | m_valid high with 0, waiting for m_ready, then IDLE
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DUR_W = 24
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        busy
`ifdef TONE_SEQUENCER_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;

  logic [7:0]       word;
  logic             wr_en;
  logic             ctrl_wr;
  logic             start_cmd;
  logic             stop_cmd;
  logic [7:0]       tbl_off;
  logic             tbl_hit;
  logic [IDX_W-1:0] tbl_idx;
  logic             tbl_dur;
  logic             tbl_we;
  logic             len_wr;
  logic [31:0]      len_merge;
  logic [LEN_W-1:0] len_next;
  logic [LEN_W-1:0] len_q;
  logic             loop_q;
  logic [31:0]      rd_val;
  logic [31:0]      tbl_thresh_a;
  logic [31:0]      tbl_dur_a;

  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] seq_ridx;
  logic [31:0]      seq_thresh;
  logic [DUR_W-1:0] seq_dur;
  logic [DUR_W-1:0] dcnt;
  logic             stop_pend;
  logic             last_entry;
  logic             silence_ack;
  logic             unused_addr;
`ifdef TONE_SEQUENCER_IRQ_EN
  logic             done_q;
`endif

  assign unused_addr = ^{addr[31:10], addr[1:0]};

  // ---------------- slave decode ----------------
  assign word      = addr[9:2];
  assign wr_en     = valid && (wstrb != 4'h0);
  assign ctrl_wr   = wr_en && (word == REG_CTRL) && wstrb[0];
  assign start_cmd = ctrl_wr && wdata[CTRL_START];
  assign stop_cmd  = ctrl_wr && wdata[CTRL_STOP];

  assign tbl_off = word - REG_TABLE;
  assign tbl_hit = (word >= REG_TABLE) && ({1'b0, tbl_off} < 9'(2 * DEPTH));
  assign tbl_idx = tbl_off[IDX_W:1];
  assign tbl_dur = tbl_off[0];
  assign tbl_we  = wr_en && tbl_hit && !busy;
  assign len_wr  = wr_en && (word == REG_LENGTH) && !busy;

  assign len_merge = apply_wstrb(32'(len_q), wdata, wstrb);
  assign len_next  = (len_merge > 32'(DEPTH)) ? LEN_W'(DEPTH) : LEN_W'(len_merge);

  always_comb begin
    rd_val = '0;
    case (word)
      REG_CTRL:   rd_val[CTRL_LOOP] = loop_q;
      REG_STATUS: begin
        rd_val[0]          = busy;
        rd_val[8 +: IDX_W] = idx;
      end
      REG_LENGTH: rd_val[LEN_W-1:0] = len_q;
`ifdef TONE_SEQUENCER_IRQ_EN
      REG_IRQ:    rd_val[0] = done_q;
`endif
      default:    if (tbl_hit) rd_val = tbl_dur ? tbl_dur_a : tbl_thresh_a;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready  <= 1'b0;
      rdata  <= '0;
      len_q  <= '0;
      loop_q <= 1'b0;
    end else begin
      ready <= valid;
      rdata <= (valid && (wstrb == 4'h0)) ? rd_val : '0;
      if (ctrl_wr) loop_q <= wdata[CTRL_LOOP];
      if (len_wr)  len_q  <= len_next;
    end
  end

  tone_seq_table #(
    .DEPTH (DEPTH),
    .DUR_W (DUR_W),
    .IDX_W (IDX_W)
  ) u_table (
    .clk       (clk),
    .resetn    (resetn),
    .we        (tbl_we),
    .wsel_dur  (tbl_dur),
    .widx      (tbl_idx),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .ridx_a    (tbl_idx),
    .rthresh_a (tbl_thresh_a),
    .rdur_a    (tbl_dur_a),
    .ridx_b    (seq_ridx),
    .rthresh_b (seq_thresh),
    .rdur_b    (seq_dur)
  );

  // ---------------- sequencer ----------------
  assign last_entry  = ({1'b0, idx} == (len_q - LEN_W'(1)));
  assign silence_ack = (state == SILENCE) && m_ready;

  // The sequencer read port looks at the entry the next transition needs:
  // entry 0 when starting, the following entry at the end of a hold.
  always_comb begin
    seq_ridx = idx;
    if (state == IDLE)      seq_ridx = '0;
    else if (state == HOLD) seq_ridx = last_entry ? '0 : idx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      idx       <= '0;
      dcnt      <= '0;
      stop_pend <= 1'b0;
      m_valid   <= 1'b0;
      m_wdata   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (start_cmd && !stop_cmd && (len_q != '0)) begin
            state   <= WRITE;
            idx     <= '0;
            m_valid <= 1'b1;
            m_wdata <= seq_thresh;
            busy    <= 1'b1;
          end
        end
        WRITE: begin
          if (m_ready) begin
            if (stop_pend || stop_cmd) begin
              // Keep m_valid high: the silencing write follows back to back.
              state     <= SILENCE;
              m_wdata   <= '0;
              stop_pend <= 1'b0;
            end else begin
              state   <= HOLD;
              m_valid <= 1'b0;
              dcnt    <= (seq_dur == '0) ? '0 : seq_dur - DUR_W'(1);
            end
          end else if (stop_cmd) begin
            stop_pend <= 1'b1;
          end
        end
        HOLD: begin
          if (stop_cmd || ((dcnt == '0) && last_entry && !loop_q)) begin
            state   <= SILENCE;
            m_valid <= 1'b1;
            m_wdata <= '0;
          end else if (dcnt == '0) begin
            state   <= WRITE;
            idx     <= seq_ridx;
            m_valid <= 1'b1;
            m_wdata <= seq_thresh;
          end else begin
            dcnt <= dcnt - DUR_W'(1);
          end
        end
        SILENCE: begin
          if (m_ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_wstrb = m_valid ? 4'hF : 4'h0;
  assign m_addr  = '0;

`ifdef TONE_SEQUENCER_IRQ_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_q <= 1'b0;
    end else if (silence_ack) begin
      done_q <= 1'b1;
    end else if (wr_en && (word == REG_IRQ) && wstrb[0] && wdata[0]) begin
      done_q <= 1'b0;
    end
  end

  assign irq = done_q;
`endif

endmodule
